// File: rtl/cordic_rotation.sv
// cordic_rotation: fully pipelined rotation-mode CORDIC, 16 registered stages.
// Q16.16 signed data. The mode field travels with each sample: 00 circular, 01 linear,
// 10 and 11 pass the sample through unchanged.
// Optional feature macro: CORDIC_GAIN_COMP_EN. When defined, circular-mode x/y are
// scaled by 1/K (39797 in Q16.16) inside the last stage.
//
// Streaming contract: there is no valid/ready handshake. A sample is taken from
// x/y/angle/mode on every rising clock edge that does not see reset, and its result
// is on the outputs exactly 16 edges later, in input order. The internal valid bit
// only marks register contents that came from a real sample. Empty slots stay at zero
// after reset, so the outputs read 0 until the first post-reset result arrives.
module cordic_rotation (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] angle,
  input  logic [1:0]  mode,
  output logic [31:0] rotated_x,
  output logic [31:0] rotated_y,
  output logic [31:0] final_angle
);

  localparam int STAGES = 16;
  localparam logic [1:0] MODE_CIRC = 2'b00;
  localparam logic [1:0] MODE_LIN  = 2'b01;

  // Rounded atan(2^-i) in Q16.16.
  localparam logic signed [31:0] ATAN [STAGES] = '{
    32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150,
    32'sd4091,  32'sd2047,  32'sd1024,  32'sd512,
    32'sd256,   32'sd128,   32'sd64,    32'sd32,
    32'sd16,    32'sd8,     32'sd4,     32'sd2
  };

  // Index 0 is the input capture register. Index i+1 holds the output of stage i.
  logic signed [31:0] x_q [STAGES+1];
  logic signed [31:0] y_q [STAGES+1];
  logic signed [31:0] z_q [STAGES+1];
  logic [1:0]         m_q [STAGES+1];
  logic               v_q [STAGES];

  // Next values computed by each stage from the register in front of it.
  logic signed [31:0] x_n [STAGES];
  logic signed [31:0] y_n [STAGES];
  logic signed [31:0] z_n [STAGES];

`ifdef CORDIC_GAIN_COMP_EN
  // Multiply by 1/K in Q16.16 with a full-width product. Arithmetic >>> 16 truncates
  // toward minus infinity.
  function automatic logic signed [31:0] gain_scale(input logic signed [31:0] v);
    logic signed [63:0] p;
    p = 64'(v) * 64'sd39797;
    return 32'(p >>> 16);
  endfunction
`endif

  // Per-stage micro-rotation. d = +1 when z >= 0. Wraparound arithmetic is intentional.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      x_n[i] = x_q[i];
      y_n[i] = y_q[i];
      z_n[i] = z_q[i];
      if (m_q[i] == MODE_CIRC) begin
        if (!z_q[i][31]) begin
          x_n[i] = x_q[i] - (y_q[i] >>> i);
          y_n[i] = y_q[i] + (x_q[i] >>> i);
          z_n[i] = z_q[i] - ATAN[i];
        end else begin
          x_n[i] = x_q[i] + (y_q[i] >>> i);
          y_n[i] = y_q[i] - (x_q[i] >>> i);
          z_n[i] = z_q[i] + ATAN[i];
        end
`ifdef CORDIC_GAIN_COMP_EN
        if (i == STAGES - 1) begin
          x_n[i] = gain_scale(x_n[i]);
          y_n[i] = gain_scale(y_n[i]);
        end
`endif
      end else if (m_q[i] == MODE_LIN) begin
        if (!z_q[i][31]) begin
          y_n[i] = y_q[i] + (x_q[i] >>> i);
          z_n[i] = z_q[i] - (32'sd65536 >>> i);
        end else begin
          y_n[i] = y_q[i] - (x_q[i] >>> i);
          z_n[i] = z_q[i] + (32'sd65536 >>> i);
        end
      end
    end
  end

  // Pipeline registers: capture every edge. Empty slots load zero so that bubbles
  // never produce a non-zero result. Reset clears every slot, including the mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
        m_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
      end
    end else begin
      x_q[0] <= x;
      y_q[0] <= y;
      z_q[0] <= angle;
      m_q[0] <= mode;
      v_q[0] <= 1'b1;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        if (v_q[i]) begin
          x_q[i+1] <= x_n[i];
          y_q[i+1] <= y_n[i];
          z_q[i+1] <= z_n[i];
          m_q[i+1] <= m_q[i];
        end else begin
          x_q[i+1] <= '0;
          y_q[i+1] <= '0;
          z_q[i+1] <= '0;
          m_q[i+1] <= '0;
        end
      end
    end
  end

  assign rotated_x   = x_q[STAGES];
  assign rotated_y   = y_q[STAGES];
  assign final_angle = z_q[STAGES];

endmodule

// File: tb/tb_cordic_rotation.sv
// tb_cordic_rotation: self-checking bench for cordic_rotation.
// It follows CORDIC_GAIN_COMP_EN so that the expected gain matches the build.
module tb_cordic_rotation;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] x, y, angle;
  logic [1:0]  mode;
  logic [31:0] rotated_x, rotated_y, final_angle;

  cordic_rotation dut (
    .clock       (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .angle       (angle),
    .mode        (mode),
    .rotated_x   (rotated_x),
    .rotated_y   (rotated_y),
    .final_angle (final_angle)
  );

  localparam int ATAN_TAB [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                                   256, 128, 64, 32, 16, 8, 4, 2};
`ifdef CORDIC_GAIN_COMP_EN
  localparam int CIRC45 = 46341;
  localparam int CIRC0  = 65536;
  localparam int CTOL   = 8;
`else
  localparam int CIRC45 = 76313;
  localparam int CIRC0  = 107922;
  localparam int CTOL   = 16;
`endif

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Runs the 16 iterations for one sample with plain integer arithmetic.
  // The int type wraps modulo 2^32.
  function automatic logic [95:0] ref_model(int xi, int yi, int zi, logic [1:0] m);
    int xv, yv, zv, xo, d;
    xv = xi; yv = yi; zv = zi;
    if (m == 2'b00 || m == 2'b01) begin
      for (int i = 0; i < 16; i++) begin
        d  = (zv >= 0) ? 1 : -1;
        xo = xv;
        if (m == 2'b00) xv = xv - d * (yv >>> i);
        yv = yv + d * (xo >>> i);
        zv = zv - d * ((m == 2'b00) ? ATAN_TAB[i] : (65536 >>> i));
      end
`ifdef CORDIC_GAIN_COMP_EN
      if (m == 2'b00) begin
        xv = int'((longint'(xv) * 64'sd39797) >>> 16);
        yv = int'((longint'(yv) * 64'sd39797) >>> 16);
      end
`endif
    end
    return {xv, yv, zv};
  endfunction

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  logic [95:0] cur_exp;

  task automatic check_val(string name, int act, int expv, int tol);
    longint diff;
    diff = longint'(act) - longint'(expv);
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > longint'(tol)) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, expv, tol);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one edge. The model queue holds the 16 results still in flight. A reset edge
  // refills it with zeros, which drops every earlier sample.
  task automatic step(logic r, logic [31:0] xi, logic [31:0] yi, logic [31:0] ai,
                      logic [1:0] mi);
    @(negedge clk);
    reset = r; x = xi; y = yi; angle = ai; mode = mi;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back('0);
      cur_exp = '0;
    end else begin
      exp_q.push_back(ref_model(int'(xi), int'(yi), int'(ai), mi));
      cur_exp = exp_q.pop_front();
    end
    #1;
    check_val("sb_x", int'(rotated_x),   int'(cur_exp[95:64]), 0);
    check_val("sb_y", int'(rotated_y),   int'(cur_exp[63:32]), 0);
    check_val("sb_z", int'(final_angle), int'(cur_exp[31:0]),  0);
  endtask

  task automatic idle_step();
    step(1'b0, 32'd0, 32'd0, 32'd0, 2'b00);
  endtask

  function automatic logic [31:0] rnd(int lo, int hi);
    return 32'($signed(lo + int'($urandom_range(0, hi - lo))));
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    int x; int y; int a; logic [1:0] m;
    int ex; int ey; int ez; int tol_x; int tol_y; int tol_z;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{65536, 0, 51472, 2'b00, CIRC45, CIRC45, 0, CTOL, CTOL, 4};
    vecs[1] = '{65536, 0, -51472, 2'b00, CIRC45, -CIRC45, 0, CTOL, CTOL, 4};
    vecs[2] = '{131072, 32768, 49152, 2'b01, 131072, 131072, 0, 0, 4, 2};
    vecs[3] = '{12345, -999, 777777, 2'b11, 12345, -999, 777777, 0, 0, 0};
    vecs[4] = '{65536, 0, 0, 2'b00, CIRC0, 0, 0, CTOL, CTOL, 4};

    reset = 1'b1; x = '0; y = '0; angle = '0; mode = '0;

    // Reset held for two edges with random inputs: outputs read zero.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
      check_val("reset_x", int'(rotated_x), 0, 0);
      check_val("reset_y", int'(rotated_y), 0, 0);
      check_val("reset_z", int'(final_angle), 0, 0);
    end

    // First post-reset sample: nothing appears before the 16th edge after capture.
    step(1'b0, 32'd65536, 32'd0, 32'd0, 2'b00);
    check_val("early_x", int'(rotated_x), 0, 0);
    for (int k = 1; k < 16; k++) begin
      idle_step();
      check_val("early_x", int'(rotated_x), 0, 0);
    end
    idle_step();
    cur_exp = ref_model(65536, 0, 0, 2'b00);
    check_val("latency_x", int'(rotated_x), int'(cur_exp[95:64]), 0);
    check_val("latency_x_gain", int'(rotated_x), CIRC0, CTOL);

    // Table-driven directed vectors with tolerance against the ideal result.
    for (int v = 0; v < 5; v++) begin
      step(1'b0, 32'(vecs[v].x), 32'(vecs[v].y), 32'(vecs[v].a), vecs[v].m);
      for (int k = 0; k < 16; k++) idle_step();
      check_val($sformatf("vec%0d_x", v), int'(rotated_x), vecs[v].ex, vecs[v].tol_x);
      check_val($sformatf("vec%0d_y", v), int'(rotated_y), vecs[v].ey, vecs[v].tol_y);
      check_val($sformatf("vec%0d_z", v), int'(final_angle), vecs[v].ez, vecs[v].tol_z);
    end

    // Back-to-back stream: circular, then linear, then reserved, with no gaps.
    for (int k = 0; k < 20; k++)
      step(1'b0, rnd(-131072, 131072), rnd(-131072, 131072), rnd(-114243, 114243), 2'b00);
    for (int k = 0; k < 20; k++)
      step(1'b0, rnd(-131072, 131072), rnd(-131072, 131072), rnd(-131071, 131071), 2'b01);
    for (int k = 0; k < 8; k++)
      step(1'b0, $urandom, $urandom, $urandom, 2'($urandom_range(2, 3)));
    // Interleaved modes, including out-of-range angles, exercise wraparound.
    for (int k = 0; k < 24; k++)
      step(1'b0, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
    for (int k = 0; k < 16; k++) idle_step();

    // Mid-stream reset with a full pipeline: no stale result may appear afterwards.
    for (int k = 0; k < 20; k++)
      step(1'b0, rnd(-131072, 131072), rnd(-131072, 131072), rnd(-114243, 114243),
           2'($urandom_range(0, 1)));
    step(1'b1, $urandom, $urandom, $urandom, 2'b00);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, rnd(-131072, 131072), rnd(-131072, 131072), rnd(-114243, 114243),
           2'($urandom_range(0, 1)));
      check_val("flush_x", int'(rotated_x), 0, 0);
      check_val("flush_y", int'(rotated_y), 0, 0);
      check_val("flush_z", int'(final_angle), 0, 0);
    end
    for (int k = 0; k < 20; k++) idle_step();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
